// File: rtl/svm_dot_if.sv
// Handshake/storage bundle for svm_dot_engine: master is the requester/feeder, slave is the engine.
interface svm_dot_if #(parameter int ACC_W = 26);
   logic                    start;
   logic signed [8:0]       feat_in;
   logic                    feat_valid;
   logic                    feat_ready;
   logic [7:0]              mem_addr;
   logic                    mem_read;
   logic signed [8:0]       mem_data;
   logic signed [ACC_W-1:0] score;
   logic                    class_out;
   logic                    done;
   logic                    busy;

   modport master (
      output start, feat_in, feat_valid, mem_data,
      input  feat_ready, mem_addr, mem_read, score, class_out, done, busy
   );

   modport slave (
      input  start, feat_in, feat_valid, mem_data,
      output feat_ready, mem_addr, mem_read, score, class_out, done, busy
   );
endinterface

// File: rtl/svm_dot_engine.sv
// Linear SVM decision engine: streams VEC_LEN feature*weight products into an accumulator.
// Macro SVM_BIAS_EN adds a BIAS state that reads the bias word at BIAS_ADDR before finishing.
module svm_dot_engine #(
   parameter int VEC_LEN   = 120,
   parameter int ACC_W     = 26,
   parameter int BIAS_ADDR = 120
) (
   input logic      clk,
   input logic      rst_n,
   svm_dot_if.slave bus
);

`ifdef SVM_BIAS_EN
   typedef enum logic [1:0] {IDLE, RUN, BIAS} state_t;
`else
   typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

   state_t                  state;
   logic signed [ACC_W-1:0] acc;
   logic [7:0]              idx;
   logic signed [17:0]      prod;
   logic signed [ACC_W-1:0] accPlusProd;
   logic signed [ACC_W-1:0] finalSum;
   logic                    handshake;
   logic                    lastIdx;

   always_comb begin
      prod        = bus.mem_data * bus.feat_in;
      accPlusProd = acc + ACC_W'(prod);
      handshake   = (state == RUN) && bus.feat_valid && bus.feat_ready;
      lastIdx     = (idx == 8'(VEC_LEN - 1));
`ifdef SVM_BIAS_EN
      finalSum    = (state == BIAS) ? (acc + ACC_W'(bus.mem_data)) : accPlusProd;
`else
      finalSum    = accPlusProd;
`endif
   end

`ifndef SVM_BIAS_EN
   logic [7:0] unused_bias_addr;
   assign unused_bias_addr = 8'(BIAS_ADDR);
`endif

   // All outputs are registered; the memory address is staged one edge ahead so
   // mem_data arrives combinationally in the cycle it is consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         acc            <= '0;
         idx            <= '0;
         bus.score      <= '0;
         bus.class_out  <= 1'b0;
         bus.done       <= 1'b0;
         bus.busy       <= 1'b0;
         bus.feat_ready <= 1'b0;
         bus.mem_read   <= 1'b0;
         bus.mem_addr   <= '0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state          <= RUN;
                  acc            <= '0;
                  idx            <= '0;
                  bus.busy       <= 1'b1;
                  bus.feat_ready <= 1'b1;
                  bus.mem_read   <= 1'b1;
                  bus.mem_addr   <= '0;
               end
            end
            RUN: begin
               if (handshake) begin
                  if (!lastIdx) begin
                     acc          <= accPlusProd;
                     idx          <= idx + 8'd1;
                     bus.mem_addr <= idx + 8'd1;
                  end else begin
`ifdef SVM_BIAS_EN
                     state          <= BIAS;
                     acc            <= accPlusProd;
                     bus.feat_ready <= 1'b0;
                     bus.mem_addr   <= 8'(BIAS_ADDR);
`else
                     state          <= IDLE;
                     bus.score      <= finalSum;
                     bus.class_out  <= ~finalSum[ACC_W-1];
                     bus.done       <= 1'b1;
                     bus.busy       <= 1'b0;
                     bus.feat_ready <= 1'b0;
                     bus.mem_read   <= 1'b0;
                     bus.mem_addr   <= '0;
`endif
                  end
               end
            end
`ifdef SVM_BIAS_EN
            BIAS: begin
               state          <= IDLE;
               bus.score      <= finalSum;
               bus.class_out  <= ~finalSum[ACC_W-1];
               bus.done       <= 1'b1;
               bus.busy       <= 1'b0;
               bus.feat_ready <= 1'b0;
               bus.mem_read   <= 1'b0;
               bus.mem_addr   <= '0;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/svm_dot_engine.md
SVM_DOT_ENGINE -- requirements
Module: svm_dot_engine

Interface
REQ-001 Parameter VEC_LEN, default 120, number of feature/weight pairs per classification (1..120).
REQ-002 Parameter ACC_W, default 26, accumulator and score width in bits.
REQ-003 Parameter BIAS_ADDR, default 120, storage address holding the bias word.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request one classification; sampled only in IDLE.
REQ-007 feat_in  input  9  signed feature sample.
REQ-008 feat_valid  input  1  feat_in is valid.
REQ-009 feat_ready  output  1  engine accepts a feature this cycle.
REQ-010 mem_addr  output  8  weight-storage read address.
REQ-011 mem_read  output  1  weight-storage read enable.
REQ-012 mem_data  input  9  signed storage read data; combinational, valid in the same cycle as mem_addr/mem_read.
REQ-013 score  output  ACC_W  signed registered decision value.
REQ-014 class_out  output  1  registered class: 1 when score >= 0, else 0.
REQ-015 done  output  1  one-cycle pulse; score/class_out updated.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, BIAS.
REQ-018 In IDLE with start=1 at an edge, the engine SHALL clear the accumulator, set the index to 0 and enter RUN.
REQ-019 In RUN, feat_ready SHALL be 1, mem_read 1, and mem_addr the current index.
REQ-020 A handshake (feat_valid & feat_ready) SHALL add the sign-extended 18-bit product mem_data*feat_in to the accumulator and increment the index.
REQ-021 A cycle without feat_valid SHALL hold the index and accumulator; there is no timeout.
REQ-022 The handshake at index VEC_LEN-1 SHALL move to BIAS (macro defined) or finish (macro undefined, REQ-031).
REQ-023 In BIAS, mem_read SHALL be 1, mem_addr BIAS_ADDR and feat_ready 0; at the next edge the engine SHALL finish using accumulator + sign-extended mem_data.
REQ-024 Finish SHALL register score and class_out from the final sum, pulse done for exactly one cycle and return to IDLE in the same edge.
REQ-025 Outside RUN/BIAS, mem_read, feat_ready and mem_addr SHALL be 0, and feat_valid SHALL be ignored.
REQ-026 start while busy SHALL be ignored; start asserted in the done cycle (state IDLE) SHALL be honoured.
REQ-027 Arithmetic SHALL be two's complement; the accumulator wraps on overflow (impossible for defaults: max |sum| < 2^23).
REQ-028 score and class_out SHALL hold their values between completions.
REQ-029 With continuous feat_valid, start sampled at edge k SHALL give done high after edge k+VEC_LEN+1 (with bias) or k+VEC_LEN (without bias).

Reset
REQ-030 rst_n low SHALL immediately force IDLE and clear accumulator, index, score, class_out, done, busy, feat_ready, mem_read and mem_addr to 0, including mid-operation; the aborted result is discarded.

Configuration
REQ-031 Macro SVM_BIAS_EN: when defined, the BIAS state exists and the word at BIAS_ADDR is added; when undefined, the BIAS state is absent, BIAS_ADDR is never read, and finish occurs at the final handshake edge using the accumulator plus the last product.

Verification
REQ-032 Weights 0..119 = 1, bias = 0, 120 features of 1, valid continuous -> score 120, class_out 1, done one cycle, exactly VEC_LEN+1 cycles after start (with SVM_BIAS_EN).
REQ-033 All 121 words = -256, features all -256 -> score 7864064, class_out 1; no wrap.
REQ-034 Weights = 1, features = -1, bias = 119 -> score -1, class_out 0; bias = 120 -> score 0, class_out 1.
REQ-035 feat_valid toggled every other cycle -> same score as continuous; done delayed by 120 cycles; index never skips.
REQ-036 start pulsed at handshake 30 -> ignored; rst_n low at handshake 50 -> all outputs 0, busy 0; a new start then yields the full correct score.
REQ-037 Without SVM_BIAS_EN, bias word = 100, REQ-032 data -> score 120, mem_addr never 120, done VEC_LEN cycles after start.
